lsu_data_aligner: RTL and testbench
===================================

# lsu_data_aligner

Parametrised load/store data aligner between the execute stage and data memory. It accepts one load or store per request and drives word-aligned memory beats with byte enables. Accesses that straddle a word boundary are split into two beats, and load data is merged and sign- or zero-extended. A registered response is returned to the pipeline. It supersedes the combinational data-refine path.

## Interface
- XLEN, 32: data/address width; legal values 32 or 64.
- ALLOW_MISALIGNED, 1: 1 splits boundary-crossing accesses; 0 flags them as errors with no memory beat.
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block in IDLE; request accepted when REQ_VALID && REQ_READY.
- LOAD, STORE  in  1 each  operation select; exactly one high for a legal request.
- FUNCT3  in  3  RISC-V width/sign code.
- ADDR  in  XLEN  byte address.
- DATA_IN  in  XLEN  store data, right-justified.
- MEM_REQ  out  1  memory beat valid; held until MEM_ACK.
- MEM_WE  out  1  write beat.
- MEM_ADDR  out  XLEN  word-aligned address; low log2(XLEN/8) bits are 0.
- MEM_BE  out  XLEN/8  byte enables.
- MEM_WDATA  out  XLEN  lane-aligned write data.
- MEM_ACK  in  1  beat complete; MEM_RDATA valid in the same cycle.
- MEM_RDATA  in  XLEN  read word.
- RESP_VALID  out  1  one-cycle response pulse.
- RESP_DATA  out  XLEN  extended load result; 0 for stores and errors.
- RESP_ERR  out  1  illegal FUNCT3, LOAD==STORE, or misaligned with ALLOW_MISALIGNED=0.

## Operation
- Width codes:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 011 LD/SD and 110 LWU are legal only when XLEN=64.
  - Store with FUNCT3[2]=1 is illegal.
- Size S bytes; offset O = ADDR mod (XLEN/8). Access is split when O+S > XLEN/8.
- Beat 0:
  - MEM_ADDR = ADDR with offset bits cleared.
  - MEM_BE = ((1<<S)-1) << O, truncated to XLEN/8 bits.
  - MEM_WDATA = DATA_IN << 8*O.
- Beat 1 (split only):
  - MEM_ADDR = beat-0 address + XLEN/8.
  - MEM_BE = remaining low bytes.
  - MEM_WDATA = DATA_IN >> 8*(XLEN/8 - O).
- Load merge: beat-0 bytes are captured into an internal buffer, and beat-1 bytes fill the upper result bytes. The result is sign-extended from bit 8S-1 for signed codes and zero-extended for U codes.
- FSM states:
  - IDLE: on accept, legal → BEAT0; illegal → RESP with RESP_ERR=1.
  - BEAT0: on MEM_ACK, split → BEAT1, else → RESP.
  - BEAT1: on MEM_ACK → RESP.
  - RESP: RESP_VALID=1 for one cycle, then → IDLE.
- Request fields are latched on accept. Input changes after accept have no effect.
- Reset values: state IDLE, REQ_READY=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, RESP_VALID=0, RESP_DATA=0, RESP_ERR=0.

## Timing
- Accept on cycle T; MEM_REQ rises at T+1 from registered outputs.
- Aligned access with MEM_ACK in the same cycle MEM_REQ rises: RESP_VALID at T+2.
- Split access: +1 cycle per beat plus any memory wait cycles. Beat-1 MEM_REQ asserts the cycle after the beat-0 ACK.
- Error response: RESP_VALID at T+1, no MEM_REQ.
- No back-to-back overlap: REQ_READY=0 from T+1 until the cycle after RESP_VALID.
- MEM_ACK sampled while MEM_REQ=0 is ignored.
- RESET_N low at any point forces all outputs to reset values asynchronously. An in-flight memory beat is abandoned, and memory must tolerate a dropped MEM_REQ.

## Structure
- Package lsu_pkg holds:
  - FUNCT3 width constants.
  - The FSM state enum.
  - size_of(funct3, xlen) and is_legal(load, store, funct3, xlen) functions.
- One sub-module, lsu_load_extend: combinational merge plus sign/zero extension, instantiated once.

## Test plan
- XLEN=32, LW ADDR=0x100, MEM_RDATA=0x8000_00F0, ACK immediate → one beat, MEM_BE=1111, RESP_DATA=0x8000_00F0 at T+2.
- LB ADDR=0x103, MEM_RDATA=0x8A00_0000 → MEM_BE=1000, RESP_DATA=0xFFFF_FF8A. LBU on the same access → 0x0000_008A.
- SH ADDR=0x203, DATA_IN=0x0000_BEEF, ALLOW_MISALIGNED=1:
  - Beat 0: MEM_ADDR=0x200, MEM_BE=1000, MEM_WDATA=0xEF00_0000.
  - Beat 1: MEM_ADDR=0x204, MEM_BE=0001, MEM_WDATA=0x0000_00BE.
- LW ADDR=0x102, ALLOW_MISALIGNED=0 → no MEM_REQ, RESP_ERR=1, RESP_VALID at T+1. LOAD=STORE=1 gives the same result.
- XLEN=64, LD ADDR=0x8 with 3 wait cycles before ACK → RESP_VALID exactly 1 cycle after ACK, REQ_READY low throughout.
- RESET_N pulsed low mid-BEAT1 → MEM_REQ drops in the same cycle, state IDLE, no RESP_VALID. The next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared width codes, FSM state encoding and request decode helpers for the
// load/store data aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes; a doubleword code on a 32-bit core is clamped to a word.
    function automatic logic [3:0] size_of(input logic [2:0] funct3, input int xlen);
        case (funct3)
            F3_B, F3_BU: size_of = 4'd1;
            F3_H, F3_HU: size_of = 4'd2;
            F3_W, F3_WU: size_of = 4'd4;
            F3_D:        size_of = (xlen >= 64) ? 4'd8 : 4'd4;
            default:     size_of = 4'd1;
        endcase
    endfunction

    function automatic logic is_legal(input logic load, input logic store,
                                      input logic [2:0] funct3, input int xlen);
        if (load == store) begin
            is_legal = 1'b0;
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W: is_legal = 1'b1;
                F3_BU, F3_HU:     is_legal = load;
                F3_D:             is_legal = (xlen == 64);
                F3_WU:            is_legal = load && (xlen == 64);
                default:          is_legal = 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Merges the two read beats of a load, right-justifies the addressed bytes
// and applies sign or zero extension to the full register width.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              lo_word,
    input  logic [XLEN-1:0]              hi_word,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              result
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] byte_mask;
    logic [3:0]      size;
    logic            msb;
    logic            sign;

    // The upper word only contributes bytes when the access crossed the boundary.
    assign raw  = XLEN'({hi_word, lo_word} >> {offset, 3'b000});
    assign size = size_of(funct3, XLEN);

    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        assign byte_mask[8*gi +: 8] = (4'(gi) < size) ? 8'hFF : 8'h00;
    end

    always_comb begin
        case (funct3[1:0])
            2'd0:    msb = raw[7];
            2'd1:    msb = raw[15];
            2'd2:    msb = raw[31];
            default: msb = raw[XLEN-1];
        endcase
    end

    assign sign   = ~funct3[2] & msb;
    assign result = (raw & byte_mask) | (~byte_mask & {XLEN{sign}});

endmodule

// File: rtl/lsu_data_aligner.sv
// Load/store aligner: turns one byte-addressed request into one or two
// word-aligned memory beats and returns a registered, extended response.
module lsu_data_aligner
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              LOAD,
    input  logic              STORE,
    input  logic [2:0]        FUNCT3,
    input  logic [XLEN-1:0]   ADDR,
    input  logic [XLEN-1:0]   DATA_IN,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [XLEN-1:0]   MEM_ADDR,
    output logic [XLEN/8-1:0] MEM_BE,
    output logic [XLEN-1:0]   MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [XLEN-1:0]   MEM_RDATA,
    output logic              RESP_VALID,
    output logic [XLEN-1:0]   RESP_DATA,
    output logic              RESP_ERR
);

    localparam int NB  = XLEN / 8;
    localparam int OW  = $clog2(NB);
    localparam int BW  = 2 * NB;
    localparam int SHW = OW + 4;

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OW-1:0]     off_q, off_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   addr_hi_q, addr_hi_d;
    logic [NB-1:0]     be_hi_q, be_hi_d;
    logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;
    logic [XLEN-1:0]   buf_q, buf_d;

    logic [OW-1:0]     req_off;
    logic [3:0]        req_size;
    logic              req_split;
    logic              req_legal;
    logic [XLEN-1:0]   req_base;
    logic [BW-1:0]     be_wide;
    logic [SHW-1:0]    hi_shift;
    logic [XLEN-1:0]   req_wdata0;
    logic [XLEN-1:0]   req_wdata1;
    logic [XLEN-1:0]   ext_lo;
    logic [XLEN-1:0]   ext_hi;
    logic [XLEN-1:0]   ext_data;
    logic              done;

    assign req_off   = ADDR[OW-1:0];
    assign req_size  = size_of(FUNCT3, XLEN);
    assign req_split = (int'(req_off) + int'(req_size)) > NB;
    assign req_legal = is_legal(LOAD, STORE, FUNCT3, XLEN) && (ALLOW_MISALIGNED || !req_split);
    assign req_base  = {ADDR[XLEN-1:OW], {OW{1'b0}}};

    // Double-width enable mask: low half is beat 0, high half is beat 1.
    assign be_wide    = ((BW'(1) << req_size) - BW'(1)) << req_off;
    assign hi_shift   = SHW'((NB - int'(req_off)) * 8);
    assign req_wdata0 = DATA_IN << {req_off, 3'b000};
    assign req_wdata1 = DATA_IN >> hi_shift;

    assign ext_lo = split_q ? buf_q : MEM_RDATA;
    assign ext_hi = split_q ? MEM_RDATA : '0;

    lsu_load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .lo_word (ext_lo),
        .hi_word (ext_hi),
        .offset  (off_q),
        .funct3  (funct3_q),
        .result  (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        store_d      = store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        addr_hi_d    = addr_hi_q;
        be_hi_d      = be_hi_q;
        wdata_hi_d   = wdata_hi_q;
        buf_d        = buf_q;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    req_ready_d = 1'b0;
                    store_d     = STORE;
                    funct3_d    = FUNCT3;
                    off_d       = req_off;
                    split_d     = req_split;
                    addr_hi_d   = req_base + XLEN'(NB);
                    be_hi_d     = be_wide[BW-1:NB];
                    wdata_hi_d  = req_wdata1;
                    if (req_legal) begin
                        state_d     = ST_BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = STORE;
                        mem_addr_d  = req_base;
                        mem_be_d    = be_wide[NB-1:0];
                        mem_wdata_d = req_wdata0;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ST_BEAT0: begin
                if (MEM_ACK) begin
                    buf_d = MEM_RDATA;
                    if (split_q) begin
                        state_d     = ST_BEAT1;
                        mem_addr_d  = addr_hi_q;
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wdata_hi_q;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (MEM_ACK) begin
                    done = 1'b1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d      = ST_RESP;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_be_d     = '0;
            mem_wdata_d  = '0;
            resp_valid_d = 1'b1;
            resp_data_d  = store_q ? '0 : ext_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= '0;
            split_q      <= 1'b0;
            addr_hi_q    <= '0;
            be_hi_q      <= '0;
            wdata_hi_q   <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            addr_hi_q    <= addr_hi_d;
            be_hi_q      <= be_hi_d;
            wdata_hi_q   <= wdata_hi_d;
            buf_q        <= buf_d;
        end
    end

    assign REQ_READY  = req_ready_q;
    assign MEM_REQ    = mem_req_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_BE     = mem_be_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_DATA  = resp_data_q;
    assign RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_lsu_data_aligner.sv
// Directed bench for lsu_data_aligner: 32-bit instances with and without
// misaligned support plus a 64-bit instance, vector table and hand sequences.
module tb_lsu_data_aligner;

    logic        clk;
    logic        rst_n;

    // Shared stimulus for the two 32-bit instances (index 0: misaligned allowed).
    logic        load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, din;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        req_valid32  [2];
    logic        req_ready32  [2];
    logic        mem_req32    [2];
    logic        mem_we32     [2];
    logic [31:0] mem_addr32   [2];
    logic [3:0]  mem_be32     [2];
    logic [31:0] mem_wdata32  [2];
    logic        resp_valid32 [2];
    logic [31:0] resp_data32  [2];
    logic        resp_err32   [2];

    logic        req_valid64, req_ready64, load64, store64;
    logic [2:0]  funct3_64;
    logic [63:0] addr64, din64, mem_addr64, mem_wdata64, mem_rdata64, resp_data64;
    logic [7:0]  mem_be64;
    logic        mem_req64, mem_we64, mem_ack64, resp_valid64, resp_err64;

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut32
        lsu_data_aligner #(
            .XLEN             (32),
            .ALLOW_MISALIGNED (gi == 0)
        ) u_dut (
            .CLK        (clk),
            .RESET_N    (rst_n),
            .REQ_VALID  (req_valid32[gi]),
            .REQ_READY  (req_ready32[gi]),
            .LOAD       (load),
            .STORE      (store),
            .FUNCT3     (funct3),
            .ADDR       (addr),
            .DATA_IN    (din),
            .MEM_REQ    (mem_req32[gi]),
            .MEM_WE     (mem_we32[gi]),
            .MEM_ADDR   (mem_addr32[gi]),
            .MEM_BE     (mem_be32[gi]),
            .MEM_WDATA  (mem_wdata32[gi]),
            .MEM_ACK    (mem_ack),
            .MEM_RDATA  (mem_rdata),
            .RESP_VALID (resp_valid32[gi]),
            .RESP_DATA  (resp_data32[gi]),
            .RESP_ERR   (resp_err32[gi])
        );
    end

    lsu_data_aligner #(
        .XLEN             (64),
        .ALLOW_MISALIGNED (1'b1)
    ) u_dut64 (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .REQ_VALID  (req_valid64),
        .REQ_READY  (req_ready64),
        .LOAD       (load64),
        .STORE      (store64),
        .FUNCT3     (funct3_64),
        .ADDR       (addr64),
        .DATA_IN    (din64),
        .MEM_REQ    (mem_req64),
        .MEM_WE     (mem_we64),
        .MEM_ADDR   (mem_addr64),
        .MEM_BE     (mem_be64),
        .MEM_WDATA  (mem_wdata64),
        .MEM_ACK    (mem_ack64),
        .MEM_RDATA  (mem_rdata64),
        .RESP_VALID (resp_valid64),
        .RESP_DATA  (resp_data64),
        .RESP_ERR   (resp_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        err;
        logic        split;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] resp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on 32-bit instance i, memory acks each beat immediately.
    task automatic txn32(input int i, input string tag, input vec_t v);
        load = v.ld; store = v.st; funct3 = v.f3; addr = v.addr; din = v.din;
        mem_ack = 1'b0;
        req_valid32[i] = 1'b1;
        @(posedge clk); #1;
        req_valid32[i] = 1'b0;
        addr = ~v.addr; din = ~v.din; funct3 = 3'b111; load = 1'b0; store = 1'b0;
        chk({tag, " ready_busy"}, 64'(req_ready32[i]), 64'd0);
        if (v.err) begin
            chk({tag, " err_valid"}, 64'(resp_valid32[i]), 64'd1);
            chk({tag, " err_flag"},  64'(resp_err32[i]),   64'd1);
            chk({tag, " err_data"},  64'(resp_data32[i]),  64'd0);
            chk({tag, " err_noreq"}, 64'(mem_req32[i]),    64'd0);
        end else begin
            chk({tag, " b0_req"},   64'(mem_req32[i]),    64'd1);
            chk({tag, " b0_valid"}, 64'(resp_valid32[i]), 64'd0);
            chk({tag, " b0_we"},    64'(mem_we32[i]),     64'(v.st));
            chk({tag, " b0_addr"},  64'(mem_addr32[i]),   64'(v.a0));
            chk({tag, " b0_be"},    64'(mem_be32[i]),     64'(v.be0));
            chk({tag, " b0_wdata"}, 64'(mem_wdata32[i]),  64'(v.wd0));
            mem_rdata = v.rd0; mem_ack = 1'b1;
            @(posedge clk); #1;
            if (v.split) begin
                chk({tag, " b1_req"},   64'(mem_req32[i]),    64'd1);
                chk({tag, " b1_valid"}, 64'(resp_valid32[i]), 64'd0);
                chk({tag, " b1_addr"},  64'(mem_addr32[i]),   64'(v.a1));
                chk({tag, " b1_be"},    64'(mem_be32[i]),     64'(v.be1));
                chk({tag, " b1_wdata"}, 64'(mem_wdata32[i]),  64'(v.wd1));
                mem_rdata = v.rd1;
                @(posedge clk); #1;
            end
            mem_ack = 1'b0; mem_rdata = 32'h0;
            chk({tag, " resp_valid"}, 64'(resp_valid32[i]), 64'd1);
            chk({tag, " resp_err"},   64'(resp_err32[i]),   64'd0);
            chk({tag, " resp_data"},  64'(resp_data32[i]),  64'(v.resp));
            chk({tag, " resp_noreq"}, 64'(mem_req32[i]),    64'd0);
        end
        @(posedge clk); #1;
        chk({tag, " pulse_end"}, 64'(resp_valid32[i]), 64'd0);
        chk({tag, " ready_back"}, 64'(req_ready32[i]), 64'd1);
    endtask

    // Non-split load on the 64-bit instance with `waits` idle cycles before ACK.
    task automatic txn64(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rd, input int waits,
                         input logic [7:0] be, input logic [63:0] resp);
        load64 = 1'b1; store64 = 1'b0; funct3_64 = f3; addr64 = a; din64 = 64'h0;
        mem_ack64 = 1'b0; mem_rdata64 = 64'hDEAD_DEAD_DEAD_DEAD;
        req_valid64 = 1'b1;
        @(posedge clk); #1;
        req_valid64 = 1'b0; addr64 = ~a;
        chk({tag, " req"},   64'(mem_req64),   64'd1);
        chk({tag, " addr"},  mem_addr64,       a & ~64'h7);
        chk({tag, " be"},    64'(mem_be64),    64'(be));
        chk({tag, " ready"}, 64'(req_ready64), 64'd0);
        for (int w = 0; w < waits; w++) begin
            @(posedge clk); #1;
            chk({tag, " wait_req"},   64'(mem_req64),    64'd1);
            chk({tag, " wait_ready"}, 64'(req_ready64),  64'd0);
            chk({tag, " wait_valid"}, 64'(resp_valid64), 64'd0);
        end
        mem_rdata64 = rd; mem_ack64 = 1'b1;
        @(posedge clk); #1;
        mem_ack64 = 1'b0;
        chk({tag, " resp_valid"}, 64'(resp_valid64), 64'd1);
        chk({tag, " resp_data"},  resp_data64,       resp);
        chk({tag, " resp_ready"}, 64'(req_ready64),  64'd0);
        @(posedge clk); #1;
        chk({tag, " pulse_end"},  64'(resp_valid64), 64'd0);
        chk({tag, " ready_back"}, 64'(req_ready64),  64'd1);
    endtask

    vec_t vecs  [14];
    vec_t nvecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ld    st    f3      addr          din           rd0           rd1           err   split a0            be0      wd0           a1            be1      wd1           resp
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h8000_00F0, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'h0,        4'b0000, 32'h0,        32'h8000_00F0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h1234_5678, 32'h8A00_0000, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h7800_0000, 32'h0,        4'b0000, 32'h0,        32'hFFFF_FF8A};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h1234_5678, 32'h8A00_0000, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h7800_0000, 32'h0,        4'b0000, 32'h0,        32'h0000_008A};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_BEEF, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0200, 4'b1000, 32'hEF00_0000, 32'h0000_0204, 4'b0001, 32'h0000_00BE, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h1234_5678, 32'hABCD_0000, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h5678_0000, 32'h0,        4'b0000, 32'h0,        32'hFFFF_ABCD};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h1234_5678, 32'h00F0_0D00, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b0110, 32'h3456_7800, 32'h0,        4'b0000, 32'h0,        32'h0000_F00D};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h1234_5678, 32'h1122_3344, 32'h5566_7788, 1'b0, 1'b1, 32'h0000_0100, 4'b1100, 32'h5678_0000, 32'h0000_0104, 4'b0011, 32'h0000_1234, 32'h7788_1122};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0303, 32'h1234_5678, 32'h9C00_0000, 32'h0000_00F1, 1'b0, 1'b1, 32'h0000_0300, 4'b1000, 32'h7800_0000, 32'h0000_0304, 4'b0001, 32'h0012_3456, 32'hFFFF_F19C};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_A500, 32'h0,        4'b0000, 32'h0,        32'h0};

        nvecs[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        nvecs[1] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0BAD_F00D, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'h0,        4'b0000, 32'h0,        32'h0BAD_F00D};
        nvecs[2] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        nvecs[3] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h1234_5678, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};

        rst_n = 1'b0;
        load = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; din = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        req_valid32[0] = 1'b0; req_valid32[1] = 1'b0;
        req_valid64 = 1'b0; load64 = 1'b0; store64 = 1'b0; funct3_64 = 3'b000;
        addr64 = 64'h0; din64 = 64'h0; mem_ack64 = 1'b0; mem_rdata64 = 64'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst ready",      64'(req_ready32[0]),  64'd1);
        chk("rst mem_req",    64'(mem_req32[0]),    64'd0);
        chk("rst mem_we",     64'(mem_we32[0]),     64'd0);
        chk("rst mem_be",     64'(mem_be32[0]),     64'd0);
        chk("rst mem_addr",   64'(mem_addr32[0]),   64'd0);
        chk("rst mem_wdata",  64'(mem_wdata32[0]),  64'd0);
        chk("rst resp_valid", 64'(resp_valid32[0]), 64'd0);
        chk("rst resp_data",  64'(resp_data32[0]),  64'd0);
        chk("rst resp_err",   64'(resp_err32[0]),   64'd0);
        chk("rst ready64",    64'(req_ready64),     64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray ACK while no beat is outstanding must be ignored.
        mem_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("idle_ack valid", 64'(resp_valid32[0]), 64'd0);
            chk("idle_ack ready", 64'(req_ready32[0]),  64'd1);
        end
        mem_ack = 1'b0;

        for (int k = 0; k < 14; k++) begin
            $display("vec a32 %0d: ld=%0b st=%0b f3=%03b addr=%08h", k, vecs[k].ld, vecs[k].st, vecs[k].f3, vecs[k].addr);
            txn32(0, $sformatf("a32v%0d", k), vecs[k]);
        end
        for (int k = 0; k < 4; k++) begin
            $display("vec n32 %0d: ld=%0b st=%0b f3=%03b addr=%08h", k, nvecs[k].ld, nvecs[k].st, nvecs[k].f3, nvecs[k].addr);
            txn32(1, $sformatf("n32v%0d", k), nvecs[k]);
        end

        $display("seq x64 LD with 3 wait cycles");
        txn64("x64ld", 3'b011, 64'h8, 64'hFEDC_BA98_7654_3210, 3, 8'hFF, 64'hFEDC_BA98_7654_3210);
        $display("seq x64 LW upper word signed");
        txn64("x64lw", 3'b010, 64'h4, 64'h8000_0001_0000_0000, 0, 8'hF0, 64'hFFFF_FFFF_8000_0001);
        $display("seq x64 LWU upper word");
        txn64("x64lwu", 3'b110, 64'h4, 64'h8000_0001_0000_0000, 0, 8'hF0, 64'h0000_0000_8000_0001);

        // Reset while the second beat of a split store is outstanding.
        $display("seq reset mid-beat1");
        load = 1'b0; store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0202; din = 32'h1122_3344;
        req_valid32[0] = 1'b1;
        @(posedge clk); #1;
        req_valid32[0] = 1'b0;
        chk("rstseq b0_req", 64'(mem_req32[0]), 64'd1);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rstseq b1_req",  64'(mem_req32[0]),  64'd1);
        chk("rstseq b1_addr", 64'(mem_addr32[0]), 64'h204);
        chk("rstseq b1_be",   64'(mem_be32[0]),   64'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq async_req",   64'(mem_req32[0]),    64'd0);
        chk("rstseq async_ready", 64'(req_ready32[0]),  64'd1);
        chk("rstseq async_be",    64'(mem_be32[0]),     64'd0);
        chk("rstseq async_addr",  64'(mem_addr32[0]),   64'd0);
        chk("rstseq async_valid", 64'(resp_valid32[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rstseq quiet_valid", 64'(resp_valid32[0]), 64'd0);
            chk("rstseq quiet_req",   64'(mem_req32[0]),    64'd0);
        end
        $display("seq LW after reset");
        txn32(0, "post_rst", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
